// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one single-port fixed-latency memory between the fetch
//             port and the load/store port (data priority, starvation guard).
//  Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              busy
);

    localparam int c_starve_w = $clog2(STARVE_MAX + 1);
    localparam int c_lat_w    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
    localparam logic [c_lat_w-1:0]    c_wait_load  = c_lat_w'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_starve_w-1:0]   r_starve_cnt;
    logic [c_starve_w-1:0]   w_starve_nxt;
    logic [c_lat_w-1:0]      r_lat_cnt;
    logic [c_lat_w-1:0]      w_lat_nxt;
    logic                    r_owner_dm;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic                    w_resp;
    logic                    w_arb;
    logic                    w_if_win;
    logic                    w_dm_win;

    always_comb begin
        w_resp       = (r_state == ST_RESP);
        w_arb        = ((r_state == ST_IDLE) || w_resp) && (if_req || dm_req);
        // Fetch wins when alone, or when it has lost STARVE_MAX times in a row
        w_if_win     = w_arb && if_req && (!dm_req || (r_starve_cnt == c_starve_max));
        w_dm_win     = w_arb && !w_if_win;
        w_state_nxt  = r_state;
        w_lat_nxt    = r_lat_cnt;
        w_starve_nxt = r_starve_cnt;

        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_state_nxt = w_arb ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                if (MEM_LAT == 1) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_lat_nxt   = c_wait_load;
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_lat_nxt = r_lat_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_arb) begin
            if (w_dm_win && if_req) begin
                w_starve_nxt = (r_starve_cnt == c_starve_max) ? r_starve_cnt
                                                              : r_starve_cnt + 1'b1;
            end else begin
                w_starve_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_lat_cnt    <= '0;
            r_owner_dm   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_lat_cnt    <= w_lat_nxt;
            r_mem_en     <= w_arb;
            if (w_arb) begin
                r_owner_dm  <= w_dm_win;
                r_mem_addr  <= w_dm_win ? dm_addr : if_addr;
                r_mem_we    <= w_dm_win & dm_we;
                r_mem_wdata <= w_dm_win ? dm_wdata : '0;
            end
        end
    end

    // Combinational outputs are gated so they read 0 for as long as rst is low
    always_comb begin
        if_gnt    = rst & w_if_win;
        dm_gnt    = rst & w_dm_win;
        if_rvalid = rst & w_resp & ~r_owner_dm;
        dm_rvalid = rst & w_resp & r_owner_dm;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
        stall_f   = rst & if_req & ~if_gnt & ~if_rvalid;
        stall_m   = rst & dm_req & ~dm_gnt & ~dm_rvalid;
        busy      = rst & (r_state != ST_IDLE);
        mem_en    = r_mem_en;
        mem_we    = r_mem_we;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Randomized bench for mem_arbiter against a cycle-count model.
//  Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int c_aw    = 32;
    localparam int c_dw    = 32;
    localparam int c_lat   = 2;
    localparam int c_smax  = 4;
    localparam int c_n_cyc = 1600;

    logic            clk       = 1'b0;
    logic            rst;
    logic            if_req    = 1'b0;
    logic [c_aw-1:0] if_addr   = '0;
    logic            if_gnt;
    logic            if_rvalid;
    logic [c_dw-1:0] if_rdata;
    logic            dm_req    = 1'b0;
    logic            dm_we     = 1'b0;
    logic [c_aw-1:0] dm_addr   = '0;
    logic [c_dw-1:0] dm_wdata  = '0;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [c_dw-1:0] dm_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_wdata;
    logic [c_dw-1:0] mem_rdata = '0;
    logic            stall_f;
    logic            stall_m;
    logic            busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (c_aw),
        .DATA_W    (c_dw),
        .MEM_LAT   (c_lat),
        .STARVE_MAX(c_smax)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_f  (stall_f),
        .stall_m  (stall_m),
        .busy     (busy)
    );

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [c_dw-1:0] init_word(input logic [c_aw-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    function automatic bit rst_sched(input int c);
        return (c < 3) || (c >= 100 && c < 102) || (c == 400) ||
               (c >= 777 && c < 780) || (c >= 1100 && c < 1103);
    endfunction

    // Memory seen by the DUT, and the bench's own view of what it must contain
    logic [c_dw-1:0] env_mem [logic [c_aw-1:0]];
    logic [c_dw-1:0] ref_mem [logic [c_aw-1:0]];
    logic [c_dw-1:0] rd_due  [int];

    // Access-level model: one access at a time, timed by cycle arithmetic
    int              next_arb  = 0;
    int              grant_cyc = 0;
    bit              have_acc  = 1'b0;
    int              starve    = 0;
    bit              acc_dm    = 1'b0;
    bit              acc_we    = 1'b0;
    logic [c_aw-1:0] acc_addr  = '0;
    logic [c_dw-1:0] acc_wdata = '0;
    logic [c_dw-1:0] acc_rdata = '0;
    bit              if_pend   = 1'b0;
    bit              dm_pend   = 1'b0;
    int              mode      = 1;

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        env_mem[32'h10] = 32'h0050_0093;
        ref_mem[32'h10] = 32'h0050_0093;

        for (int c = 0; c < c_n_cyc; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            // 0: fetch-only at 0x10, 1: idle, 2: saturated contention, 3: random
            if (c < 3)        mode = 1;
            else if (c < 13)  mode = 0;
            else if (c < 33)  mode = 1;
            else if (c < 200) mode = 2;
            else              mode = 3;
            rst = !rst_sched(c);

            if (mode == 1) begin
                if_pend = 1'b0;
                dm_pend = 1'b0;
            end
            if (!if_pend) begin
                if (mode == 0 || mode == 2 || (mode == 3 && $urandom_range(0, 99) < 40)) begin
                    if_pend = 1'b1;
                    if_addr = (mode == 0) ? 32'h10 : (c_aw'($urandom_range(0, 15)) << 2);
                end
            end else if (mode == 3 && $urandom_range(0, 99) < 3) begin
                if_pend = 1'b0;
            end
            if (!dm_pend) begin
                if (mode == 2 || (mode == 3 && $urandom_range(0, 99) < 45)) begin
                    dm_pend  = 1'b1;
                    dm_we    = 1'($urandom_range(0, 1));
                    dm_addr  = c_aw'($urandom_range(0, 15)) << 2;
                    dm_wdata = c_dw'($urandom);
                end
            end else if (mode == 3 && $urandom_range(0, 99) < 3) begin
                dm_pend = 1'b0;
            end
            if_req    = if_pend;
            dm_req    = dm_pend;
            mem_rdata = rd_due.exists(c) ? rd_due[c] : c_dw'($urandom);
            #1;

            if (!rst) begin
                check_val("rst_if_gnt",    32'(if_gnt),    32'd0);
                check_val("rst_dm_gnt",    32'(dm_gnt),    32'd0);
                check_val("rst_if_rvalid", 32'(if_rvalid), 32'd0);
                check_val("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
                check_val("rst_stall_f",   32'(stall_f),   32'd0);
                check_val("rst_stall_m",   32'(stall_m),   32'd0);
                check_val("rst_busy",      32'(busy),      32'd0);
                check_val("rst_mem_en",    32'(mem_en),    32'd0);
                check_val("rst_mem_we",    32'(mem_we),    32'd0);
                check_val("rst_mem_addr",  mem_addr,       32'd0);
                check_val("rst_mem_wdata", mem_wdata,      32'd0);
                check_val("rst_if_rdata",  if_rdata,       32'd0);
                check_val("rst_dm_rdata",  dm_rdata,       32'd0);
                have_acc = 1'b0;
                starve   = 0;
                next_arb = 0;
            end else begin
                bit e_en, e_resp, e_busy, e_ifv, e_dmv, arb, e_ifg, e_dmg;
                e_en   = have_acc && (c == grant_cyc + 1);
                e_resp = have_acc && (c == grant_cyc + 1 + c_lat);
                e_busy = have_acc && (c > grant_cyc) && (c <= grant_cyc + 1 + c_lat);
                if (e_en) begin
                    if (acc_we) ref_mem[acc_addr] = acc_wdata;
                    else acc_rdata = ref_mem.exists(acc_addr) ? ref_mem[acc_addr] : init_word(acc_addr);
                end
                e_ifv = e_resp && !acc_dm;
                e_dmv = e_resp && acc_dm;
                arb   = (c >= next_arb) && (if_req || dm_req);
                e_ifg = arb && if_req && (!dm_req || starve == c_smax);
                e_dmg = arb && !e_ifg;

                check_val("if_gnt",    32'(if_gnt),    32'(e_ifg));
                check_val("dm_gnt",    32'(dm_gnt),    32'(e_dmg));
                check_val("mem_en",    32'(mem_en),    32'(e_en));
                check_val("busy",      32'(busy),      32'(e_busy));
                check_val("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
                check_val("dm_rvalid", 32'(dm_rvalid), 32'(e_dmv));
                check_val("stall_f",   32'(stall_f),   32'(if_req && !e_ifg && !e_ifv));
                check_val("stall_m",   32'(stall_m),   32'(dm_req && !e_dmg && !e_dmv));
                if (e_en) begin
                    check_val("mem_addr", mem_addr,     acc_addr);
                    check_val("mem_we",   32'(mem_we),  32'(acc_we));
                    if (acc_we) check_val("mem_wdata", mem_wdata, acc_wdata);
                end
                if (e_ifv)            check_val("if_rdata", if_rdata, acc_rdata);
                if (e_dmv && !acc_we) check_val("dm_rdata", dm_rdata, acc_rdata);

                if (arb) begin
                    if (e_dmg && if_req) starve = (starve < c_smax) ? starve + 1 : c_smax;
                    else                 starve = 0;
                    acc_dm    = e_dmg;
                    acc_addr  = e_dmg ? dm_addr : if_addr;
                    acc_we    = e_dmg && dm_we;
                    acc_wdata = dm_wdata;
                    grant_cyc = c;
                    next_arb  = c + 1 + c_lat;
                    have_acc  = 1'b1;
                    if (e_ifg) if_pend = 1'b0;
                    if (e_dmg) dm_pend = 1'b0;
                end
            end

            if (mem_en) begin
                if (mem_we) env_mem[mem_addr] = mem_wdata;
                else rd_due[c + c_lat] = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
